// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared MCPU widths, opcodes and master IDs
// Exports WORD_SIZE/ADDR_SIZE, opcode field sizes, OP_* constants, wait counter width, mst_e
package mcpu_pkg;
   localparam int WORD_SIZE    = 16;
   localparam int ADDR_SIZE    = 8;
   localparam int OPCODE_SIZE  = 4;
   localparam int OPERAND_SIZE = WORD_SIZE - OPCODE_SIZE;
   localparam int WAIT_W       = 8;
   localparam logic [OPCODE_SIZE-1:0] OP_HLT = 4'h0;
   localparam logic [OPCODE_SIZE-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_SIZE-1:0] OP_STA = 4'h2;
   localparam logic [OPCODE_SIZE-1:0] OP_ADD = 4'h3;
   localparam logic [OPCODE_SIZE-1:0] OP_SUB = 4'h4;
   localparam logic [OPCODE_SIZE-1:0] OP_JMP = 4'h5;
   localparam logic [OPCODE_SIZE-1:0] OP_JZ  = 4'h6;
   localparam logic [OPCODE_SIZE-1:0] OP_NOP = 4'hF;
   typedef enum logic {MST_CPU = 1'b0, MST_LOADER = 1'b1} mst_e;
endpackage

// File: rtl/mcpu_mem_arbiter_if.sv
// mcpu_mem_arbiter_if: both master request/response ports plus the RAM port
// slave modport = arbiter view; master modport = masters + RAM view
interface mcpu_mem_arbiter_if;
   import mcpu_pkg::*;
   logic                 m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [ADDR_SIZE-1:0] m0_addr;
   logic [WORD_SIZE-1:0] m0_wdata, m0_rdata;
   logic                 m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [ADDR_SIZE-1:0] m1_addr;
   logic [WORD_SIZE-1:0] m1_wdata, m1_rdata;
   logic                 ram_en, ram_we;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [WORD_SIZE-1:0] ram_wdata, ram_rdata;
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, ram_rdata,
      output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
             ram_en, ram_we, ram_addr, ram_wdata
   );
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, ram_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mcpu_arb_pick.sv
// mcpu_arb_pick: combinational winner select between the CPU and loader masters
// Inputs: m0_req, m1_req, last_win, wait_cnt; outputs: pick0, pick1 (one-hot or zero)
module mcpu_arb_pick
   import mcpu_pkg::*;
#(
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 8
) (
   input  logic              m0_req,
   input  logic              m1_req,
   input  mst_e              last_win,
   input  logic [WAIT_W-1:0] wait_cnt,
   output logic              pick0,
   output logic              pick1
);
   // under contention the loader wins on its RR turn, or once it has starved long enough
   logic m1_turn;
   assign m1_turn = (RR_MODE != 0) ? (last_win == MST_CPU) : (wait_cnt >= 8'(MAX_WAIT));
   assign pick1   = m1_req & (~m0_req | m1_turn);
   assign pick0   = m0_req & ~pick1;
endmodule

// File: rtl/mcpu_mem_arbiter.sv
// mcpu_mem_arbiter: two-master arbiter in front of the MCPU single-port 256-word RAM
// Ports: clk; reset (async, active low); bus (slave modport) with m0_*, m1_* master ports and ram_*
module mcpu_mem_arbiter
   import mcpu_pkg::*;
#(
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 8
) (
   input logic               clk,
   input logic               reset,
   mcpu_mem_arbiter_if.slave bus
);
   logic                 pick0, pick1, gnt0, gnt1, rd_pend, rv0, rv1;
   logic [WAIT_W-1:0]    wait_cnt;
   mst_e                 last_win, rd_owner;
   logic [WORD_SIZE-1:0] hold0, hold1;
   mcpu_arb_pick #(.RR_MODE(RR_MODE), .MAX_WAIT(MAX_WAIT)) u_pick (
      .m0_req   (bus.m0_req),
      .m1_req   (bus.m1_req),
      .last_win (last_win),
      .wait_cnt (wait_cnt),
      .pick0    (pick0),
      .pick1    (pick1)
   );
   assign gnt0          = pick0 & reset;
   assign gnt1          = pick1 & reset;
   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.ram_en    = gnt0 | gnt1;
   assign bus.ram_we    = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
   assign bus.ram_addr  = gnt1 ? bus.m1_addr : gnt0 ? bus.m0_addr : '0;
   assign bus.ram_wdata = gnt1 ? bus.m1_wdata : gnt0 ? bus.m0_wdata : '0;
   // RAM data arrives the cycle after the grant; pass it straight through, then hold it
   assign rv0           = rd_pend & (rd_owner == MST_CPU);
   assign rv1           = rd_pend & (rd_owner == MST_LOADER);
   assign bus.m0_rvalid = rv0;
   assign bus.m1_rvalid = rv1;
   assign bus.m0_rdata  = rv0 ? bus.ram_rdata : hold0;
   assign bus.m1_rdata  = rv1 ? bus.ram_rdata : hold1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         last_win <= MST_LOADER;
         rd_pend  <= 1'b0;
         rd_owner <= MST_CPU;
         hold0    <= '0;
         hold1    <= '0;
      end else begin
         // the loader never drops an ungranted request, so clearing on !m1_req is holding at zero
         wait_cnt <= (gnt1 | ~bus.m1_req) ? '0 : (&wait_cnt) ? wait_cnt : wait_cnt + 8'd1;
         if (gnt0 | gnt1) last_win <= gnt1 ? MST_LOADER : MST_CPU;
         rd_pend  <= bus.ram_en & ~bus.ram_we;
         rd_owner <= gnt1 ? MST_LOADER : MST_CPU;
         if (rv0) hold0 <= bus.ram_rdata;
         if (rv1) hold1 <= bus.ram_rdata;
      end
   end
endmodule
